// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: shared types and constants for the DMem load/store path.
//   DataPath / DataAddrPath : 32-bit data word and byte address
//   MemSize                 : access size of a core request
//   DAccState               : access-unit FSM states
//   access_misaligned()     : alignment rule for half/word accesses
package dmem_access_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int HALF_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] DataPath;
    typedef logic [ADDR_WIDTH-1:0] DataAddrPath;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } MemSize;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_ADDR = 3'd1,
        LD_DATA = 3'd2,
        ST_WR   = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5,
        ERR     = 3'd6
    } DAccState;

    // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic access_misaligned(input MemSize size, input logic [1:0] lane);
        case (size)
            MEM_HALF: return lane[0];
            MEM_WORD: return (lane != 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_lane_unit.sv
// dmem_lane_unit: combinational lane logic shared by loads and sub-word stores.
//   size, is_unsigned, lane : access size, zero-extend flag, byte address bits [1:0]
//   rdata_word              : word read from DMem
//   store_data              : store data (low bits significant)
//   load_result             : selected lane, sign/zero-extended to a word
//   merged_word             : rdata_word with the target lane replaced by store_data
// Little-endian: byte lane = lane[1:0], half lane = lane[1] (lane[0] ignored for halves).
module dmem_lane_unit
    import dmem_access_unit_pkg::*;
(
    input  MemSize      size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  DataPath     rdata_word,
    input  DataPath     store_data,
    output DataPath     load_result,
    output DataPath     merged_word
);

    logic [BYTE_WIDTH-1:0] byte_lane;
    logic [HALF_WIDTH-1:0] half_lane;

    always_comb begin
        byte_lane   = '0;
        half_lane   = '0;
        load_result = '0;
        merged_word = rdata_word;

        case (lane)
            2'd0:    byte_lane = rdata_word[7:0];
            2'd1:    byte_lane = rdata_word[15:8];
            2'd2:    byte_lane = rdata_word[23:16];
            default: byte_lane = rdata_word[31:24];
        endcase
        half_lane = lane[1] ? rdata_word[31:16] : rdata_word[15:0];

        case (size)
            MEM_BYTE: begin
                load_result = is_unsigned
                    ? {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, byte_lane}
                    : {{(DATA_WIDTH-BYTE_WIDTH){byte_lane[BYTE_WIDTH-1]}}, byte_lane};
                case (lane)
                    2'd0:    merged_word[7:0]   = store_data[7:0];
                    2'd1:    merged_word[15:8]  = store_data[7:0];
                    2'd2:    merged_word[23:16] = store_data[7:0];
                    default: merged_word[31:24] = store_data[7:0];
                endcase
            end
            MEM_HALF: begin
                load_result = is_unsigned
                    ? {{(DATA_WIDTH-HALF_WIDTH){1'b0}}, half_lane}
                    : {{(DATA_WIDTH-HALF_WIDTH){half_lane[HALF_WIDTH-1]}}, half_lane};
                if (lane[1]) merged_word[31:16] = store_data[15:0];
                else         merged_word[15:0]  = store_data[15:0];
            end
            default: begin
                load_result = rdata_word;
                merged_word = store_data;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: converts byte/half/word loads and stores from the core into
// aligned word accesses on a registered-input DMem (read data one cycle after
// the address; sub-word stores are done as read-modify-write).
//   clk, rst (async, active-low)
//   req/reqStore/reqSize/reqUnsigned/reqAddr/reqData : request, sampled when busy=0
//   busy, done, rdata, misaligned                    : core-side status/result
//   memAddr, memWData, memWe, memRData               : DMem port
// Build option: DMEM_ACCESS_ALIGN_CHECK_EN -- when defined, misaligned half/word
// accesses are rejected through ERR; otherwise low address bits are ignored.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        reqStore,
    input  MemSize      reqSize,
    input  logic        reqUnsigned,
    input  DataAddrPath reqAddr,
    input  DataPath     reqData,
    output logic        busy,
    output logic        done,
    output DataPath     rdata,
    output logic        misaligned,
    output DataAddrPath memAddr,
    output DataPath     memWData,
    output logic        memWe,
    input  DataPath     memRData
);

    DAccState    state_q, state_d;
    logic        store_q, store_d;
    MemSize      size_q, size_d;
    logic        uns_q, uns_d;
    DataAddrPath addr_q, addr_d;
    DataPath     data_q, data_d;

    DataPath     load_result;
    DataPath     merged_word;

    dmem_lane_unit u_lane (
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane        (addr_q[1:0]),
        .rdata_word  (memRData),
        .store_data  (data_q),
        .load_result (load_result),
        .merged_word (merged_word)
    );

    // State and captured request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            size_q  <= MEM_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    store_d = reqStore;
                    size_d  = reqSize;
                    uns_d   = reqUnsigned;
                    addr_d  = reqAddr;
                    data_d  = reqData;
`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
                    if (access_misaligned(reqSize, reqAddr[1:0])) state_d = ERR;
                    else
`endif
                    if (!reqStore)                                state_d = LD_ADDR;
                    else if (reqSize == MEM_WORD)                 state_d = ST_WR;
                    else                                          state_d = RMW_RD;
                end
            end
            LD_ADDR: state_d = LD_DATA;
            LD_DATA: state_d = IDLE;
            ST_WR:   state_d = IDLE;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; all of them fall to zero on async reset
    always_comb begin
        busy       = (state_q != IDLE);
        done       = 1'b0;
        rdata      = '0;
        misaligned = 1'b0;
        memAddr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        memWData   = '0;
        memWe      = 1'b0;

        case (state_q)
            LD_DATA: begin
                done  = 1'b1;
                rdata = load_result;
            end
            ST_WR: begin
                done     = 1'b1;
                memWData = data_q;
                memWe    = 1'b1;
            end
            RMW_WR: begin
                done     = 1'b1;
                memWData = merged_word;
                memWe    = 1'b1;
            end
`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
            ERR: begin
                done       = 1'b1;
                misaligned = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed bench for dmem_access_unit with a DMem model
// (registered addr/data/we, read data one cycle after address, write commits
// on the edge after it is latched).
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        reqStore = 1'b0;
    MemSize      reqSize = MEM_WORD;
    logic        reqUnsigned = 1'b0;
    DataAddrPath reqAddr = '0;
    DataPath     reqData = '0;
    logic        busy, done, misaligned, memWe;
    DataPath     rdata, memWData, memRData;
    DataAddrPath memAddr;

    dmem_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .reqStore    (reqStore),
        .reqSize     (reqSize),
        .reqUnsigned (reqUnsigned),
        .reqAddr     (reqAddr),
        .reqData     (reqData),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .misaligned  (misaligned),
        .memAddr     (memAddr),
        .memWData    (memWData),
        .memWe       (memWe),
        .memRData    (memRData)
    );

    always #5 clk = ~clk;

    // DMem model
    logic [31:0] mem [0:63];
    logic [31:0] dm_addr_l = '0;
    logic [31:0] dm_wdata_l = '0;
    logic        dm_we_l = 1'b0;
    always @(posedge clk) begin
        if (dm_we_l) mem[dm_addr_l[7:2]] <= dm_wdata_l;
        dm_addr_l  <= memAddr;
        dm_wdata_l <= memWData;
        dm_we_l    <= memWe;
    end
    assign memRData = mem[dm_addr_l[7:2]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Results of the last access
    logic        r_done_seen, r_mis, r_busy1, r_done_after, r_busy_after, r_we_after;
    int unsigned r_lat, r_we_cnt;
    logic [31:0] r_rdata, r_wdata, r_addr;

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
    task automatic access(input logic st, input MemSize sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d);
        int unsigned cyc;
        req = 1'b1; reqStore = st; reqSize = sz; reqUnsigned = uns; reqAddr = a; reqData = d;
        r_done_seen = 1'b0; r_lat = 0; r_rdata = '0; r_mis = 1'b0; r_we_cnt = 0; r_wdata = '0;
        @(negedge clk);
        req = 1'b0;
        r_busy1 = busy;
        r_addr  = memAddr;
        cyc = 1;
        while (!r_done_seen && cyc <= 8) begin
            if (memWe) begin r_we_cnt++; r_wdata = memWData; end
            if (done) begin
                r_done_seen = 1'b1; r_lat = cyc; r_rdata = rdata; r_mis = misaligned;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        r_done_after = done;
        r_busy_after = busy;
        r_we_after   = memWe;
    endtask

    task automatic expect_access(input string tag, input int unsigned lat, input logic [31:0] rd,
                                 input int unsigned wes, input logic [31:0] wd, input logic mis);
        check({tag, "_done"}, 32'(r_done_seen), 32'd1);
        check({tag, "_lat"}, r_lat, lat);
        check({tag, "_rdata"}, r_rdata, rd);
        check({tag, "_we_cycles"}, r_we_cnt, wes);
        check({tag, "_wdata"}, r_wdata, wd);
        check({tag, "_mis"}, 32'(r_mis), 32'(mis));
        check({tag, "_busy"}, 32'(r_busy1), 32'd1);
        check({tag, "_pulse"}, {29'd0, r_done_after, r_busy_after, r_we_after}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[32'h10 >> 2] = 32'h11223344;
        mem[32'h20 >> 2] = 32'h80FF7F01;
        mem[32'h04 >> 2] = 32'h13579BDF;

        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_memaddr", memAddr, 32'd0);
        check("rst_memwdata", memWData, 32'd0);
        check("rst_memwe", 32'(memWe), 32'd0);

        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        access(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0);
        expect_access("lw10", 2, 32'h11223344, 0, 32'h0, 1'b0);
        check("lw10_memaddr", r_addr, 32'h10);

        access(1'b0, MEM_BYTE, 1'b0, 32'h23, 32'h0);
        expect_access("lb23", 2, 32'hFFFFFF80, 0, 32'h0, 1'b0);
        check("lb23_memaddr", r_addr, 32'h20);
        access(1'b0, MEM_BYTE, 1'b1, 32'h23, 32'h0);
        expect_access("lbu23", 2, 32'h00000080, 0, 32'h0, 1'b0);
        access(1'b0, MEM_HALF, 1'b0, 32'h20, 32'h0);
        expect_access("lh20", 2, 32'h00007F01, 0, 32'h0, 1'b0);
        access(1'b0, MEM_HALF, 1'b0, 32'h22, 32'h0);
        expect_access("lh22", 2, 32'hFFFF80FF, 0, 32'h0, 1'b0);
        access(1'b0, MEM_HALF, 1'b1, 32'h22, 32'h0);
        expect_access("lhu22", 2, 32'h000080FF, 0, 32'h0, 1'b0);
        access(1'b0, MEM_BYTE, 1'b0, 32'h21, 32'h0);
        expect_access("lb21", 2, 32'h0000007F, 0, 32'h0, 1'b0);

        access(1'b1, MEM_BYTE, 1'b0, 32'h11, 32'h000000AB);
        expect_access("sb11", 2, 32'h0, 1, 32'h1122AB44, 1'b0);
        access(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0);
        expect_access("lw10_after_sb", 2, 32'h1122AB44, 0, 32'h0, 1'b0);

        access(1'b1, MEM_HALF, 1'b0, 32'h12, 32'h0000BEEF);
        expect_access("sh12", 2, 32'h0, 1, 32'hBEEFAB44, 1'b0);
        access(1'b0, MEM_HALF, 1'b0, 32'h12, 32'h0);
        expect_access("lh12", 2, 32'hFFFFBEEF, 0, 32'h0, 1'b0);
        access(1'b1, MEM_WORD, 1'b0, 32'h10, 32'hCAFEF00D);
        expect_access("sw10", 1, 32'h0, 1, 32'hCAFEF00D, 1'b0);
        access(1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0);
        expect_access("lw10_after_sw", 2, 32'hCAFEF00D, 0, 32'h0, 1'b0);

`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
        access(1'b0, MEM_WORD, 1'b0, 32'h06, 32'h0);
        expect_access("lw06", 1, 32'h0, 0, 32'h0, 1'b1);
        access(1'b0, MEM_HALF, 1'b0, 32'h21, 32'h0);
        expect_access("lh21", 1, 32'h0, 0, 32'h0, 1'b1);
        access(1'b1, MEM_WORD, 1'b0, 32'h06, 32'hDEADBEEF);
        expect_access("sw06", 1, 32'h0, 0, 32'h0, 1'b1);
        access(1'b0, MEM_WORD, 1'b0, 32'h04, 32'h0);
        expect_access("lw04", 2, 32'h13579BDF, 0, 32'h0, 1'b0);
`else
        access(1'b0, MEM_WORD, 1'b0, 32'h06, 32'h0);
        expect_access("lw06", 2, 32'h13579BDF, 0, 32'h0, 1'b0);
        check("lw06_memaddr", r_addr, 32'h04);
        access(1'b0, MEM_HALF, 1'b0, 32'h21, 32'h0);
        expect_access("lh21", 2, 32'h00007F01, 0, 32'h0, 1'b0);
`endif

        // Reset while the RMW read is in flight
        req = 1'b1; reqStore = 1'b1; reqSize = MEM_BYTE; reqUnsigned = 1'b0;
        reqAddr = 32'h20; reqData = 32'h00000055;
        @(negedge clk);
        req = 1'b0;
        check("rmw_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_mis", 32'(misaligned), 32'd0);
        check("mid_rst_memaddr", memAddr, 32'd0);
        check("mid_rst_memwdata", memWData, 32'd0);
        check("mid_rst_memwe", 32'(memWe), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        access(1'b0, MEM_WORD, 1'b0, 32'h20, 32'h0);
        expect_access("lw20_after_rst", 2, 32'h80FF7F01, 0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store access unit between the core's memory stage and the word-wide data memory (DMem). Converts byte/halfword/word loads and stores into aligned 32-bit word accesses, including a read-modify-write sequence for sub-word stores. Provides a busy/done handshake to the core and drives DMem's address, data and write-enable inputs.

## Interface
- No module parameters; widths come from the shared package: DATA_WIDTH = 32, DataPath, DataAddrPath.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- req  in  1  request strobe; sampled only while busy=0
- reqStore  in  1  1 = store, 0 = load
- reqSize  in  MemSize  MEM_BYTE / MEM_HALF / MEM_WORD
- reqUnsigned  in  1  load zero-extends when 1, sign-extends when 0
- reqAddr  in  DataAddrPath  byte address
- reqData  in  DataPath  store data in the low bits
- busy  out  1  request in flight
- done  out  1  one-cycle completion pulse
- rdata  out  DataPath  load result; valid only while done=1 for a load
- misaligned  out  1  valid with done; access rejected
- memAddr  out  DataAddrPath  word-aligned address to DMem (bits [1:0] = 0)
- memWData  out  DataPath  write data to DMem
- memWe  out  1  write enable to DMem
- memRData  in  DataPath  DMem read data

## Operation
- The design is little-endian. Byte lane = addr[1:0]; half lane = addr[1].
- DMem behaviour this block depends on:
  - DMem registers addr, data and we on each clk edge.
  - Read data is valid in the cycle after the address is presented.
  - A write commits on the edge after it is latched.
- On acceptance (IDLE, req=1), the unit registers the op, size, unsigned flag, address and data.
- FSM states: IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_RD, RMW_WR, ERR.
  - IDLE: busy=0; req moves to ERR if misaligned; otherwise load → LD_ADDR, word store → ST_WR, byte/half store → RMW_RD.
  - LD_ADDR: drive memAddr, memWe=0 → LD_DATA.
  - LD_DATA: done=1; rdata = lane extracted from memRData and extended → IDLE.
  - ST_WR: memAddr, memWData=reqData, memWe=1, done=1 → IDLE.
  - RMW_RD: drive memAddr, memWe=0 → RMW_WR.
  - RMW_WR: memWData = memRData with the target lane replaced; memWe=1, done=1 → IDLE.
  - ERR: done=1, misaligned=1, rdata=0, memWe=0 → IDLE.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.
- memWe is asserted only in ST_WR and RMW_WR, for exactly one cycle.
- rdata, memWData and misaligned are 0 whenever they are not meaningful.
- memAddr holds its last value in IDLE.
- req while busy=1 is ignored; the core holds off until busy=0.

## Timing
- Reset (async assert) values: state IDLE; busy, done, rdata, misaligned, memAddr, memWData, memWe all 0.
- Latency counts cycles after the acceptance cycle:
  - load: 2, done in LD_DATA
  - word store: 1
  - sub-word store: 2
  - misaligned: 1
- Back-to-back requests:
  - A new req may be accepted in the cycle after done.
  - A store followed by a load to the same word returns the new data; the DMem write commits before the load's read cycle.
- Reset mid-operation:
  - The FSM returns to IDLE and memWe deasserts immediately.
  - An RMW_RD in flight writes nothing.
  - A write already latched by DMem may still commit.

## Configuration
- DMEM_ACCESS_ALIGN_CHECK_EN defined: misaligned accesses go to ERR as described above.
- Undefined:
  - The ERR state is not built and misaligned is tied to 0.
  - Low address bits are ignored for alignment: a half uses addr[1], a word is forced to the aligned word.

## Structure
- Types package entries:
  - MemSize enum
  - DAccState enum
  - lane helper constants (BYTE_WIDTH = 8, HALF_WIDTH = 16)
- Sub-module dmem_lane_unit (combinational):
  - extract + sign/zero-extend for loads
  - lane merge for stores
  - instantiated once, shared by the load and RMW paths.

## Test plan
- LW at 0x10 (word 0x11223344): done 2 cycles after acceptance, rdata=0x11223344, memWe never high.
- Word 0x80FF7F01 at 0x20:
  - LB 0x23 → 0xFFFFFF80
  - LBU 0x23 → 0x00000080
  - LH 0x20 → 0x00007F01
- SB 0xAB at 0x11 over 0x11223344:
  - memWe high exactly 1 cycle with memWData=0x1122AB44.
  - An immediately following LW 0x10 returns 0x1122AB44.
- SH 0xBEEF at 0x12, then LH 0x12 back-to-back: rdata=0xFFFFBEEF; a second SW at 0x12's word then overwrites it with 0xCAFEF00D.
- LW at 0x06:
  - Macro defined: done+misaligned 1 cycle after acceptance, no DMem write.
  - Macro undefined: returns the word at 0x04.
- rst asserted during RMW_RD:
  - All outputs 0 asynchronously and the target word is unchanged.
  - After release, LW succeeds normally.
